// File: rtl/sdram_pkg.sv
// Shared SDRAM width constants, address field slices and the fetch FSM encoding.
package sdram_pkg;

  localparam int SD_ADDR_W  = 24;
  localparam int SD_DATA_W  = 16;
  localparam int SD_BURST_W = 9;
  localparam int SD_LEN_W   = 16;

  // Address layout: {bank[23:22], row[21:9], col[8:0]}
  localparam int SD_BANK_MSB = 23;
  localparam int SD_BANK_LSB = 22;
  localparam int SD_ROW_MSB  = 21;
  localparam int SD_ROW_LSB  = 9;
  localparam int SD_COL_MSB  = 8;
  localparam int SD_COL_LSB  = 0;

  typedef logic [SD_ADDR_W-1:0]  sd_addr_t;
  typedef logic [SD_DATA_W-1:0]  sd_data_t;
  typedef logic [SD_BURST_W-1:0] sd_burst_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_SPACE = 2'd1,
    ST_REQ        = 2'd2,
    ST_XFER       = 2'd3
  } fetch_state_t;

  function automatic logic [1:0] sd_bank(input sd_addr_t a);
    return a[SD_BANK_MSB:SD_BANK_LSB];
  endfunction

  function automatic logic [12:0] sd_row(input sd_addr_t a);
    return a[SD_ROW_MSB:SD_ROW_LSB];
  endfunction

  function automatic logic [8:0] sd_col(input sd_addr_t a);
    return a[SD_COL_MSB:SD_COL_LSB];
  endfunction

endpackage

// File: rtl/sdram_read_fetcher_if.sv
// Read-side request/ack port between the fetcher (master) and the SDRAM controller (slave).
// Handshake: master raises sd_req with sd_addr/sd_burst stable and holds all three until the
// first sd_ack; sd_addr/sd_burst stay stable until the last ack of the job. Each cycle with
// sd_ack=1 carries exactly one valid sd_data word; ack gaps are legal. sd_wr is always 0.
interface sdram_read_fetcher_if;
  import sdram_pkg::*;

  logic      sd_req;
  logic      sd_wr;
  sd_addr_t  sd_addr;
  sd_burst_t sd_burst;
  logic      sd_ack;
  sd_data_t  sd_data;

  modport master (
    output sd_req, sd_wr, sd_addr, sd_burst,
    input  sd_ack, sd_data
  );

  modport slave (
    input  sd_req, sd_wr, sd_addr, sd_burst,
    output sd_ack, sd_data
  );
endinterface

// File: rtl/sdram_fetch_fifo.sv
// Synchronous first-word-fall-through FIFO with a free-count output for space reservation.
module sdram_fetch_fifo #(
  parameter int DEPTH_LOG2 = 9,
  parameter int DATA_W     = 16
) (
  input  logic                clk,
  input  logic                res,
  input  logic                push,
  input  logic [DATA_W-1:0]   push_data,
  input  logic                pop,
  output logic [DATA_W-1:0]   head,
  output logic                not_empty,
  output logic [DEPTH_LOG2:0] free_cnt
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign not_empty = (count != '0);
  assign free_cnt  = (DEPTH_LOG2+1)'(DEPTH) - count;
  assign do_push   = push && (free_cnt != '0);
  assign do_pop    = pop && not_empty;
  // Head reads as zero while empty so the output is defined after reset.
  assign head      = not_empty ? mem[rd_ptr] : '0;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/sdram_read_fetcher.sv
// Splits a linear read command into controller bursts, buffers returned words and streams them out.
module sdram_read_fetcher
  import sdram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int MAX_BURST  = 256
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 cmd_start,
  input  logic [SD_ADDR_W-1:0] cmd_addr,
  input  logic [SD_LEN_W-1:0]  cmd_len,
  output logic                 cmd_busy,
  output logic                 cmd_done,
  sdram_read_fetcher_if.master sd,
  output logic [SD_DATA_W-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output fetch_state_t         dbg_state
);
  fetch_state_t          state;
  sd_addr_t              addr;
  logic [SD_LEN_W-1:0]   remaining;
  logic [9:0]            ack_cnt;
  logic [9:0]            job_len;
  logic                  sd_req_q;
  sd_addr_t              sd_addr_q;
  sd_burst_t             sd_burst_q;

  logic [SD_LEN_W-1:0]   chunk;
  logic [DEPTH_LOG2:0]   chunk_cmp;
  logic [DEPTH_LOG2:0]   free_cnt;
  logic                  push;
  logic [9:0]            ack_next;
  logic                  job_end;

  assign sd.sd_req   = sd_req_q;
  assign sd.sd_wr    = 1'b0;
  assign sd.sd_addr  = sd_addr_q;
  assign sd.sd_burst = sd_burst_q;
  assign dbg_state   = state;

  assign chunk     = (remaining > SD_LEN_W'(MAX_BURST)) ? SD_LEN_W'(MAX_BURST) : remaining;
  assign chunk_cmp = (DEPTH_LOG2+1)'(chunk);
  // Acks outside REQ/XFER are stray and never reach the FIFO.
  assign push      = sd.sd_ack && ((state == ST_REQ) || (state == ST_XFER));
  assign ack_next  = ack_cnt + 10'd1;
  assign job_end   = push && (ack_next == job_len);

  sdram_fetch_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (SD_DATA_W)
  ) u_fifo (
    .clk       (clk),
    .res       (res),
    .push      (push),
    .push_data (sd.sd_data),
    .pop       (out_ready),
    .head      (out_data),
    .not_empty (out_valid),
    .free_cnt  (free_cnt)
  );

  // Command/job sequencer with registered controller-side outputs.
  always_ff @(posedge clk) begin
    if (res) begin
      state      <= ST_IDLE;
      addr       <= '0;
      remaining  <= '0;
      ack_cnt    <= '0;
      job_len    <= '0;
      sd_req_q   <= 1'b0;
      sd_addr_q  <= '0;
      sd_burst_q <= '0;
      cmd_busy   <= 1'b0;
      cmd_done   <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_start && (cmd_len != '0)) begin
            addr      <= cmd_addr;
            remaining <= cmd_len;
            cmd_busy  <= 1'b1;
            state     <= ST_WAIT_SPACE;
          end
        end
        ST_WAIT_SPACE: begin
          // Reserve FIFO room for the whole job before asking for it.
          if (free_cnt >= chunk_cmp) begin
            sd_addr_q  <= addr;
            sd_burst_q <= SD_BURST_W'(chunk - SD_LEN_W'(1));
            job_len    <= 10'(chunk);
            ack_cnt    <= '0;
            sd_req_q   <= 1'b1;
            state      <= ST_REQ;
          end
        end
        ST_REQ, ST_XFER: begin
          if (push) begin
            ack_cnt  <= ack_next;
            sd_req_q <= 1'b0;
            if (job_end) begin
              addr      <= addr + SD_ADDR_W'(job_len);
              remaining <= remaining - SD_LEN_W'(job_len);
              if (remaining == SD_LEN_W'(job_len)) begin
                cmd_done <= 1'b1;
                cmd_busy <= 1'b0;
                state    <= ST_IDLE;
              end else begin
                state <= ST_WAIT_SPACE;
              end
            end else begin
              state <= ST_XFER;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_read_fetcher.sv
// Self-checking bench: random controller model, random consumer, queue-based reference model.
module tb_sdram_read_fetcher;
  import sdram_pkg::*;

  localparam int DEPTH_LOG2 = 9;
  localparam int MAX_BURST  = 256;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         res = 1'b1;
  logic         cmd_start = 1'b0;
  logic [23:0]  cmd_addr = '0;
  logic [15:0]  cmd_len = '0;
  logic         cmd_busy;
  logic         cmd_done;
  logic [15:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  fetch_state_t dbg_state;

  sdram_read_fetcher_if sd ();

  sdram_read_fetcher #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk       (clk),
    .res       (res),
    .cmd_start (cmd_start),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_busy  (cmd_busy),
    .cmd_done  (cmd_done),
    .sd        (sd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic [23:0] job_addr_q[$];
  logic [8:0]  job_burst_q[$];
  int          ready_mode = 1;
  bit          spurious_en = 0;
  int          gap_after = -1;
  int          gap_len = 0;
  int          last_ack_cyc = 0;
  int          acked_words = 0;
  int          jobs_seen = 0;
  int          words_out = 0;
  int          exp_words = 0;
  int          done_cnt = 0;
  int          done_base = 0;
  int          done_cyc = 0;
  logic        busy_at_done = 1'b0;
  logic [23:0] last_job_addr = '0;
  logic [8:0]  last_job_burst = '0;
  bit          ctl_busy = 0;
  int          ctl_idx = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Data the controller model returns for a given word address.
  function automatic logic [15:0] word_of(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], 8'hA5};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- controller model ----------------
  initial begin : ctl_model
    logic [23:0] c_addr;
    logic [8:0]  c_burst;
    int          c_total;
    int          c_wait;
    bit          c_stable;
    bit          c_first_chk;
    c_addr = '0; c_burst = '0; c_total = 0; c_wait = 0; c_stable = 1; c_first_chk = 0;
    sd.sd_ack = 1'b0;
    sd.sd_data = '0;
    forever begin
      tick();
      sd.sd_ack = 1'b0;
      if (res) begin
        ctl_busy = 0;
        c_first_chk = 0;
        continue;
      end
      if (c_first_chk) begin
        check_eq("req_low_after_first_ack", sd.sd_req, 1'b0);
        c_first_chk = 0;
      end
      if (!ctl_busy) begin
        if (sd.sd_req) begin
          c_addr = sd.sd_addr;
          c_burst = sd.sd_burst;
          c_total = int'(c_burst) + 1;
          ctl_idx = 0;
          c_wait = $urandom_range(0, 3);
          c_stable = 1;
          ctl_busy = 1;
          jobs_seen++;
          last_job_addr = c_addr;
          last_job_burst = c_burst;
          check_eq("job_expected", job_addr_q.size() != 0, 1'b1);
          if (job_addr_q.size() != 0) begin
            check_eq("job_addr", c_addr, job_addr_q.pop_front());
            check_eq("job_burst", c_burst, job_burst_q.pop_front());
          end
        end else if (spurious_en && ($urandom_range(0, 3) == 0)) begin
          sd.sd_ack = 1'b1;
          sd.sd_data = 16'($urandom);
        end
      end
      if (ctl_busy) begin
        if ((sd.sd_addr !== c_addr) || (sd.sd_burst !== c_burst)) c_stable = 0;
        if ((ctl_idx == 0) && (sd.sd_req !== 1'b1)) c_stable = 0;
        if (c_wait > 0) begin
          c_wait--;
        end else begin
          sd.sd_ack = 1'b1;
          sd.sd_data = word_of(c_addr + 24'(ctl_idx));
          if (ctl_idx == 0) c_first_chk = 1;
          ctl_idx++;
          acked_words++;
          last_ack_cyc = cyc;
          if (ctl_idx == gap_after) c_wait = gap_len;
          else c_wait = ($urandom_range(0, 3) == 0) ? 1 : 0;
          if (ctl_idx == c_total) begin
            ctl_busy = 0;
            check_eq("job_bus_stable", c_stable, 1'b1);
          end
        end
      end
    end
  end

  // ---------------- consumer ----------------
  initial begin : consumer
    forever begin
      tick();
      if (res) begin
        out_ready = 1'b0;
        continue;
      end
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (out_valid && out_ready) begin
        words_out++;
        check_eq("out_word_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check_eq("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- done monitor ----------------
  initial begin : done_mon
    forever begin
      tick();
      if (cmd_done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = cmd_busy;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_cmd(input logic [23:0] a, input logic [15:0] n);
    int          left;
    int          c;
    logic [23:0] ja;
    for (int i = 0; i < int'(n); i++) exp_q.push_back(word_of(a + 24'(i)));
    left = int'(n);
    ja = a;
    while (left > 0) begin
      c = (left > MAX_BURST) ? MAX_BURST : left;
      job_addr_q.push_back(ja);
      job_burst_q.push_back(9'(c - 1));
      ja = ja + 24'(c);
      left -= c;
    end
    exp_words = int'(n);
    words_out = 0;
    jobs_seen = 0;
    acked_words = 0;
    done_base = done_cnt;
    cmd_addr = a;
    cmd_len = n;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    check_eq("busy_one_after_start", cmd_busy, 1'b1);
    tick();
    check_eq("req_two_after_start", sd.sd_req, 1'b1);
  endtask

  task automatic finish_cmd();
    int budget;
    budget = 20000;
    while ((done_cnt == done_base) && (budget > 0)) begin
      tick();
      budget--;
    end
    check_eq("done_seen", done_cnt != done_base, 1'b1);
    if (done_cnt != done_base) begin
      check_eq("done_one_after_last_ack", done_cyc, last_ack_cyc + 1);
      check_eq("busy_low_at_done", busy_at_done, 1'b0);
    end
    budget = 20000;
    while ((exp_q.size() != 0) && (budget > 0)) begin
      tick();
      budget--;
    end
    repeat (4) tick();
    check_eq("single_done", done_cnt - done_base, 1);
    check_eq("words_out", words_out, exp_words);
    check_eq("exp_q_drained", exp_q.size(), 0);
    check_eq("jobs_all_issued", job_addr_q.size(), 0);
    check_eq("out_valid_empty", out_valid, 1'b0);
    check_eq("idle_after_cmd", dbg_state, ST_IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main_seq
    logic [23:0] ra;
    logic [15:0] rl;
    int          budget;
    logic [15:0] edge_len[4];

    repeat (3) tick();
    check_eq("rst_sd_req", sd.sd_req, 1'b0);
    check_eq("rst_sd_wr", sd.sd_wr, 1'b0);
    check_eq("rst_sd_addr", sd.sd_addr, 24'h0);
    check_eq("rst_sd_burst", sd.sd_burst, 9'h0);
    check_eq("rst_cmd_busy", cmd_busy, 1'b0);
    check_eq("rst_cmd_done", cmd_done, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_data", out_data, 16'h0);
    res = 1'b0;
    tick();

    // Zero-length strobe is ignored.
    cmd_addr = 24'h00ABCD; cmd_len = 16'd0; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    check_eq("len0_not_busy", cmd_busy, 1'b0);
    tick();
    check_eq("len0_no_req", sd.sd_req, 1'b0);

    // Short single job.
    ready_mode = 1;
    start_cmd(24'h000010, 16'd4);
    finish_cmd();
    check_eq("t1_job_addr", last_job_addr, 24'h000010);
    check_eq("t1_job_burst", last_job_burst, 9'd3);
    check_eq("t1_jobs", jobs_seen, 1);

    // Multi-job command; a strobe while busy must not be queued.
    start_cmd(24'h012300, 16'd600);
    repeat (10) tick();
    cmd_addr = 24'h123456; cmd_len = 16'd5; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    finish_cmd();
    check_eq("t2_jobs", jobs_seen, 3);
    check_eq("t2_last_addr", last_job_addr, 24'h012500);
    check_eq("t2_last_burst", last_job_burst, 9'd87);

    // Page-wrap ack gap in the middle of a job.
    gap_after = 16; gap_len = 7;
    start_cmd(24'h0001F0, 16'd32);
    finish_cmd();
    gap_after = -1; gap_len = 0;

    // Back-pressure: FIFO fills, requests stop, then resume.
    ready_mode = 0;
    start_cmd(24'h200000, 16'd1024);
    budget = 5000;
    while ((acked_words < 512) && (budget > 0)) begin
      tick();
      budget--;
    end
    repeat (30) tick();
    check_eq("bp_words_held", acked_words, 512);
    check_eq("bp_no_req", sd.sd_req, 1'b0);
    check_eq("bp_wait_space", dbg_state, ST_WAIT_SPACE);
    check_eq("bp_out_valid", out_valid, 1'b1);
    ready_mode = 1;
    finish_cmd();
    check_eq("bp_jobs", jobs_seen, 4);

    // Address wrap modulo 2^24.
    start_cmd(24'hFFFFFE, 16'd260);
    finish_cmd();
    check_eq("wrap_job2_addr", last_job_addr, 24'h0000FE);
    check_eq("wrap_job2_burst", last_job_burst, 9'd3);

    // Reset in the middle of a transfer.
    start_cmd(24'h3456A0, 16'd600);
    budget = 2000;
    while (!(ctl_busy && (ctl_idx >= 5)) && (budget > 0)) begin
      tick();
      budget--;
    end
    check_eq("mid_xfer_reached", ctl_busy && (ctl_idx >= 5), 1'b1);
    res = 1'b1;
    tick();
    check_eq("rst_mid_sd_req", sd.sd_req, 1'b0);
    check_eq("rst_mid_out_valid", out_valid, 1'b0);
    check_eq("rst_mid_cmd_busy", cmd_busy, 1'b0);
    exp_q.delete();
    job_addr_q.delete();
    job_burst_q.delete();
    tick();
    res = 1'b0;
    tick();
    start_cmd(24'h000400, 16'd40);
    finish_cmd();

    // Boundary lengths around MAX_BURST.
    ready_mode = 2;
    spurious_en = 1;
    edge_len[0] = 16'd1;
    edge_len[1] = 16'd256;
    edge_len[2] = 16'd257;
    edge_len[3] = 16'd512;
    for (int i = 0; i < 4; i++) begin
      ra = 24'($urandom);
      start_cmd(ra, edge_len[i]);
      finish_cmd();
    end

    // Random commands with random back-pressure and stray acks.
    for (int i = 0; i < 6; i++) begin
      ra = 24'($urandom);
      rl = 16'($urandom_range(1, 700));
      if ($urandom_range(0, 1) == 1) begin
        gap_after = $urandom_range(1, 20);
        gap_len = $urandom_range(2, 9);
      end else begin
        gap_after = -1;
        gap_len = 0;
      end
      start_cmd(ra, rl);
      finish_cmd();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin : watchdog
    #3000000;
    failures++;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end
endmodule
